// File: rtl/bp_update_sched.sv
// Branch-predictor table write scheduler: post-reset clear sweep, then an
// in-order FIFO of EX training records drained one per accepted write.
// Ports: clock/reset (async, active-low); ex_valid/ex_cond/ex_taken/ex_pc/
// ex_tg_pc two EX slots (bit 0 older); ex_stall to EX; upd_ready from the
// table port; upd_we/upd_clear/upd_idx/upd_pc/upd_tg_pc/upd_taken/upd_cond
// write request; init_busy to fetch; q_count occupancy; ovf_err sticky drop.
// Optional macro BP_UPD_COALESCE_EN: when both slots hit the same index,
// only the younger record is queued.
module bp_update_sched #(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 5,
    parameter int QDEPTH    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                ex_valid,
    input  logic [1:0]                ex_cond,
    input  logic [1:0]                ex_taken,
    input  logic [2*XLEN-1:0]         ex_pc,
    input  logic [2*XLEN-1:0]         ex_tg_pc,
    output logic                      ex_stall,
    input  logic                      upd_ready,
    output logic                      upd_we,
    output logic                      upd_clear,
    output logic [BHT_IDX_W-1:0]      upd_idx,
    output logic [XLEN-1:0]           upd_pc,
    output logic [XLEN-1:0]           upd_tg_pc,
    output logic                      upd_taken,
    output logic                      upd_cond,
    output logic                      init_busy,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      ovf_err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int IW = BHT_IDX_W;
    localparam logic [IW-1:0] SWEEP_LAST = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state, state_nx;
    logic [IW-1:0] sweep, sweep_nx;

    logic [XLEN-1:0]   q_pc [QDEPTH];
    logic [XLEN-1:0]   q_tg [QDEPTH];
    logic [QDEPTH-1:0] q_taken;
    logic [QDEPTH-1:0] q_cond;
    logic [PW-1:0]     head, tail, tail1;
    logic [CW-1:0]     count, free;
    logic              ovf;

    logic [XLEN-1:0] pc0, pc1, tg0, tg1;
    logic            coal, first_s1, drop, pop;
    logic [1:0]      n_req, n_push;

    assign pc0 = ex_pc[XLEN-1:0];
    assign pc1 = ex_pc[2*XLEN-1:XLEN];
    assign tg0 = ex_tg_pc[XLEN-1:0];
    assign tg1 = ex_tg_pc[2*XLEN-1:XLEN];

    // Space is judged on the registered count only; a pop this cycle
    // does not make room for this cycle's enqueue.
    assign free  = CW'(QDEPTH) - count;
    assign tail1 = tail + PW'(1);
    assign pop   = (state == RUN) && (count != '0) && upd_ready;

    assign ex_stall = (free < CW'(2)) || !reset;
    assign q_count  = count;
    assign ovf_err  = ovf;

    always_comb begin
        coal = 1'b0;
`ifdef BP_UPD_COALESCE_EN
        coal = (ex_valid == 2'b11) &&
               (pc0[IW+1:2] == pc1[IW+1:2]);
`endif
        // The first queued record comes from slot 1 when slot 0 is
        // absent or has been folded into the younger record.
        first_s1 = coal || (ex_valid == 2'b10);
        if (coal) begin
            n_req = 2'd1;
        end else begin
            n_req = {1'b0, ex_valid[0]} + {1'b0, ex_valid[1]};
        end
        if (free >= CW'(n_req)) begin
            n_push = n_req;
        end else begin
            n_push = free[1:0];
        end
        drop = (n_push != n_req);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_nx;
            sweep <= sweep_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sweep_nx  = sweep;
        upd_we    = 1'b0;
        upd_clear = 1'b0;
        upd_idx   = '0;
        upd_pc    = '0;
        upd_tg_pc = '0;
        upd_taken = 1'b0;
        upd_cond  = 1'b0;
        init_busy = 1'b1;
        unique case (state)
            INIT: begin
                upd_we    = reset;
                upd_clear = reset;
                upd_idx   = reset ? sweep : '0;
                if (upd_ready) begin
                    sweep_nx = sweep + IW'(1);
                    if (sweep == SWEEP_LAST) begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                init_busy = 1'b0;
                if (count != '0) begin
                    upd_we    = 1'b1;
                    upd_idx   = q_pc[head][IW+1:2];
                    upd_pc    = q_pc[head];
                    upd_tg_pc = q_tg[head];
                    upd_taken = q_taken[head];
                    upd_cond  = q_cond[head];
                end
            end
            default: begin
                state_nx = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
            ovf   <= ovf | drop;
        end
    end

    // Payload storage carries no reset; occupancy gates every read.
    always_ff @(posedge clock) begin
        if (reset && (n_push != 2'd0)) begin
            q_pc[tail]    <= first_s1 ? pc1 : pc0;
            q_tg[tail]    <= first_s1 ? tg1 : tg0;
            q_taken[tail] <= first_s1 ? ex_taken[1] : ex_taken[0];
            q_cond[tail]  <= first_s1 ? ex_cond[1] : ex_cond[0];
        end
        if (reset && (n_push == 2'd2)) begin
            q_pc[tail1]    <= pc1;
            q_tg[tail1]    <= tg1;
            q_taken[tail1] <= ex_taken[1];
            q_cond[tail1]  <= ex_cond[1];
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Testbench for bp_update_sched: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bp_update_sched;

    localparam int XLEN = 32;
    localparam int IW   = 5;
    localparam int QD   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        ex_valid, ex_cond, ex_taken;
    logic [2*XLEN-1:0] ex_pc, ex_tg_pc;
    logic              upd_ready;
    logic              ex_stall, upd_we, upd_clear, upd_taken, upd_cond;
    logic              init_busy, ovf_err;
    logic [IW-1:0]     upd_idx;
    logic [XLEN-1:0]   upd_pc, upd_tg_pc;
    logic [2:0]        q_count;

    int n_tests = 0;
    int n_fail  = 0;

    bp_update_sched dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_cond(ex_cond),
        .ex_taken(ex_taken), .ex_pc(ex_pc),
        .ex_tg_pc(ex_tg_pc), .ex_stall(ex_stall),
        .upd_ready(upd_ready), .upd_we(upd_we),
        .upd_clear(upd_clear), .upd_idx(upd_idx),
        .upd_pc(upd_pc), .upd_tg_pc(upd_tg_pc),
        .upd_taken(upd_taken), .upd_cond(upd_cond),
        .init_busy(init_busy), .q_count(q_count),
        .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic        clr;
        logic [4:0]  idx;
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        logic        cd;
        logic        busy;
    } upd_t;

    typedef struct packed {
        logic       stall;
        logic [2:0] cnt;
        logic       ovf;
    } st_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        logic        cd;
    } rec_t;

    upd_t act;
    st_t  act_st;
    assign act = {upd_we, upd_clear, upd_idx, upd_pc, upd_tg_pc,
                  upd_taken, upd_cond, init_busy};
    assign act_st = {ex_stall, q_count, ovf_err};

    // Reference model: table-clear phase, then a bounded record queue.
    rec_t m_q[$];
    rec_t m_inc[$];
    int   m_sz;
    int   m_sweep = 0;
    bit   m_init  = 1'b1;
    bit   m_ovf   = 1'b0;
    int   m_pops  = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_sweep = 0;
            m_init  = 1'b1;
            m_ovf   = 1'b0;
            m_pops  = 0;
        end else begin
            m_sz = m_q.size();
            m_inc.delete();
            if (ex_valid[0])
                m_inc.push_back('{ex_pc[31:0], ex_tg_pc[31:0],
                                  ex_taken[0], ex_cond[0]});
            if (ex_valid[1])
                m_inc.push_back('{ex_pc[63:32], ex_tg_pc[63:32],
                                  ex_taken[1], ex_cond[1]});
`ifdef BP_UPD_COALESCE_EN
            if (ex_valid == 2'b11 && ex_pc[6:2] == ex_pc[38:34])
                void'(m_inc.pop_front());
`endif
            if (m_init) begin
                if (upd_ready) begin
                    if (m_sweep == 31) m_init = 1'b0;
                    m_sweep = (m_sweep + 1) % 32;
                end
            end else if (upd_ready && m_sz > 0) begin
                void'(m_q.pop_front());
                m_pops++;
            end
            foreach (m_inc[k]) begin
                if (k < QD - m_sz) m_q.push_back(m_inc[k]);
                else m_ovf = 1'b1;
            end
        end
    end

    function automatic upd_t exp_upd();
        upd_t e;
        e = '0;
        if (!reset) begin
            e.busy = 1'b1;
        end else if (m_init) begin
            e.we   = 1'b1;
            e.clr  = 1'b1;
            e.idx  = m_sweep[4:0];
            e.busy = 1'b1;
        end else if (m_q.size() > 0) begin
            e.we  = 1'b1;
            e.idx = m_q[0].pc[6:2];
            e.pc  = m_q[0].pc;
            e.tg  = m_q[0].tg;
            e.tk  = m_q[0].tk;
            e.cd  = m_q[0].cd;
        end
        return e;
    endfunction

    function automatic st_t exp_st();
        st_t s;
        s.stall = !reset || (m_q.size() > 2);
        s.cnt   = 3'(m_q.size());
        s.ovf   = m_ovf;
        return s;
    endfunction

    function automatic upd_t mk(logic we, logic clr, logic [4:0] idx,
                                logic [31:0] pc, logic [31:0] tg,
                                logic tk, logic cd, logic busy);
        upd_t e;
        e = {we, clr, idx, pc, tg, tk, cd, busy};
        return e;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        upd_ready = 1'b1;
        ex_valid = '0; ex_cond = '0; ex_taken = '0;
        ex_pc = '0; ex_tg_pc = '0;
        repeat (3) tick();
        n_tests++;
        if (act !== mk(0, 0, 0, 0, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL reset_out got %h want busy only", act);
        end
        n_tests++;
        if (act_st !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL reset_st got %b want 10000", act_st);
        end
    endtask

    task automatic test_sweep();
        upd_ready = 1'b1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (act !== mk(1, 1, 5'(i), 0, 0, 0, 0, 1)) begin
                n_fail++;
                $display("FAIL sweep_%0d got %h want idx %0d", i, act, i);
            end
            tick();
        end
        n_tests++;
        if (act !== mk(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL sweep_end got %h want idle", act);
        end
    endtask

    task automatic test_sweep_backpressure();
        int e_idx, held, cyc;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        e_idx = 0; held = 0; cyc = 0;
        while (e_idx < 32 && cyc < 100) begin
            upd_ready = !(e_idx == 7 && held < 3);
            if (!upd_ready) held++;
            n_tests++;
            if (act !== mk(1, 1, 5'(e_idx), 0, 0, 0, 0, 1)) begin
                n_fail++;
                $display("FAIL bp_sweep cyc %0d got %h want idx %0d",
                         cyc, act, e_idx);
            end
            tick();
            cyc++;
            if (upd_ready) e_idx++;
        end
        upd_ready = 1'b1;
        n_tests++;
        if (cyc !== 35 || init_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_len got %0d busy %b want 35 busy 0",
                     cyc, init_busy);
        end
    endtask

    task automatic test_ordering();
        upd_ready = 1'b1;
        ex_valid = 2'b11; ex_taken = 2'b01; ex_cond = 2'b11;
        ex_pc    = {32'h0000_000C, 32'h0000_0008};
        ex_tg_pc = {32'h0000_0040, 32'h0000_0014};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (act !== mk(1, 0, 2, 32'h8, 32'h14, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL order_0 got %h want pc 8 idx 2", act);
        end
        tick();
        n_tests++;
        if (act !== mk(1, 0, 3, 32'hC, 32'h40, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL order_1 got %h want pc c idx 3", act);
        end
        tick();
        n_tests++;
        if (act.we !== 1'b0) begin
            n_fail++;
            $display("FAIL order_end got we %b want 0", act.we);
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] pcs [4];
        pcs = '{32'h20, 32'h24, 32'h28, 32'h2C};
        upd_ready = 1'b0;
        ex_taken = 2'b10; ex_cond = 2'b01;
        ex_valid = 2'b11;
        ex_pc = {pcs[1], pcs[0]}; ex_tg_pc = {32'h1, 32'h2};
        tick();
        ex_pc = {pcs[3], pcs[2]};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (act_st !== 5'b1_100_0) begin
            n_fail++;
            $display("FAIL fill_full got %b want 11000", act_st);
        end
        ex_valid = 2'b01;
        ex_pc = {32'h0, 32'h30};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (act_st !== 5'b1_100_1) begin
            n_fail++;
            $display("FAIL fill_drop got %b want 11001", act_st);
        end
        upd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (act.we !== 1'b1 || act.pc !== pcs[k] ||
                ex_stall !== (4 - k > 2)) begin
                n_fail++;
                $display("FAIL fill_pop_%0d got pc %h stall %b want %h %b",
                         k, act.pc, ex_stall, pcs[k], (4 - k > 2));
            end
            tick();
        end
        n_tests++;
        if (act.we !== 1'b0 || act_st !== 5'b0_000_1) begin
            n_fail++;
            $display("FAIL fill_end got we %b st %b want 0 00001",
                     act.we, act_st);
        end
    endtask

    task automatic test_wrap();
        int k;
        k = (3 - (m_pops % QD) + QD) % QD;
        upd_ready = 1'b0;
        ex_taken = 2'b00; ex_cond = 2'b11; ex_tg_pc = '0;
        for (int j = 0; j < k; j++) begin
            ex_valid = 2'b01;
            ex_pc = {32'h0, 32'h100 + 32'(4 * j)};
            tick();
        end
        ex_valid = 2'b00;
        upd_ready = 1'b1;
        for (int j = 0; j < k; j++) tick();
        upd_ready = 1'b0;
        ex_valid = 2'b11;
        ex_pc = {32'h204, 32'h200};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (q_count !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_q2 got %0d want 2", q_count);
        end
        upd_ready = 1'b1;
        tick();
        n_tests++;
        if (q_count !== 3'd1 || act.pc !== 32'h204) begin
            n_fail++;
            $display("FAIL wrap_q1 got %0d pc %h want 1 204",
                     q_count, act.pc);
        end
        ex_valid = 2'b11;
        ex_pc = {32'h20C, 32'h208};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (q_count !== 3'd2 || act.pc !== 32'h208) begin
            n_fail++;
            $display("FAIL wrap_q2b got %0d pc %h want 2 208",
                     q_count, act.pc);
        end
        tick();
        n_tests++;
        if (q_count !== 3'd1 || act.pc !== 32'h20C) begin
            n_fail++;
            $display("FAIL wrap_last got %0d pc %h want 1 20c",
                     q_count, act.pc);
        end
        tick();
        n_tests++;
        if (q_count !== 3'd0 || act.we !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_end got %0d we %b want 0 0",
                     q_count, act.we);
        end
    endtask

    task automatic test_reset_mid_run();
        upd_ready = 1'b0;
        ex_valid = 2'b11;
        ex_pc = {32'h304, 32'h300};
        tick();
        ex_valid = 2'b01;
        ex_pc = {32'h0, 32'h308};
        tick();
        ex_valid = 2'b00;
        n_tests++;
        if (q_count !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_q3 got %0d want 3", q_count);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (act !== mk(0, 0, 0, 0, 0, 0, 0, 1) ||
            act_st !== 5'b1_000_0) begin
            n_fail++;
            $display("FAIL mid_rst got %h st %b want busy 10000",
                     act, act_st);
        end
        tick();
        upd_ready = 1'b1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (act !== mk(1, 1, 5'(i), 0, 0, 0, 0, 1)) begin
                n_fail++;
                $display("FAIL mid_sweep_%0d got %h want idx %0d",
                         i, act, i);
            end
            tick();
        end
        n_tests++;
        if (act !== mk(0, 0, 0, 0, 0, 0, 0, 0) || q_count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_end got %h q %0d want idle 0",
                     act, q_count);
        end
    endtask

    task automatic test_coalesce();
        upd_ready = 1'b1;
        ex_valid = 2'b11; ex_taken = 2'b10; ex_cond = 2'b11;
        ex_pc    = {32'h100, 32'h80};
        ex_tg_pc = {32'h600, 32'h500};
        tick();
        ex_valid = 2'b00;
`ifdef BP_UPD_COALESCE_EN
        n_tests++;
        if (act !== mk(1, 0, 0, 32'h100, 32'h600, 1, 1, 0) ||
            q_count !== 3'd1) begin
            n_fail++;
            $display("FAIL coal_one got %h q %0d want pc 100 q 1",
                     act, q_count);
        end
`else
        n_tests++;
        if (act !== mk(1, 0, 0, 32'h80, 32'h500, 0, 1, 0) ||
            q_count !== 3'd2) begin
            n_fail++;
            $display("FAIL coal_s0 got %h q %0d want pc 80 q 2",
                     act, q_count);
        end
        tick();
        n_tests++;
        if (act !== mk(1, 0, 0, 32'h100, 32'h600, 1, 1, 0)) begin
            n_fail++;
            $display("FAIL coal_s1 got %h want pc 100", act);
        end
`endif
        tick();
        n_tests++;
        if (act.we !== 1'b0) begin
            n_fail++;
            $display("FAIL coal_end got we %b want 0", act.we);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            n_tests++;
            if (act !== exp_upd()) begin
                n_fail++;
                $display("FAIL rnd_out c%0d got %h want %h",
                         c, act, exp_upd());
            end
            n_tests++;
            if (act_st !== exp_st()) begin
                n_fail++;
                $display("FAIL rnd_st c%0d got %b want %b",
                         c, act_st, exp_st());
            end
            upd_ready = ($urandom_range(0, 3) != 0);
            ex_valid  = 2'($urandom_range(0, 3));
            ex_taken  = 2'($urandom_range(0, 3));
            ex_cond   = 2'($urandom_range(0, 3));
            ex_pc     = {32'($urandom_range(0, 63)) << 2,
                         32'($urandom_range(0, 63)) << 2};
            ex_tg_pc  = {32'($urandom), 32'($urandom)};
            tick();
        end
        ex_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_sweep_backpressure();
        test_ordering();
        test_fill_stall();
        test_wrap();
        test_reset_mid_run();
        test_coalesce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Schedules every write into the branch predictor tables (BHT/BTB). The tables have one write port.
- Two sources compete for that port:
  - the post-reset table-clear sweep;
  - up to two resolved-branch training records per cycle from the two EX branch slots.
- Buffers EX records in an in-order FIFO and drains one per accepted write.
- Sits between EX branch resolution and the predictor table write port. Tells fetch when predictions are not yet valid.

Parameters:
- XLEN, 32, address width.
- BHT_IDX_W, 5, table index width (2^BHT_IDX_W entries).
- QDEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (0 = in reset).
- ex_valid  in  2  per-slot resolved-branch record valid; bit 0 is the older slot.
- ex_cond  in  2  per-slot record is a conditional branch.
- ex_taken  in  2  per-slot resolved direction.
- ex_pc  in  2*XLEN  per-slot branch PC.
- ex_tg_pc  in  2*XLEN  per-slot resolved target.
- ex_stall  out  1  EX must not present new records this cycle.
- upd_ready  in  1  table write port accepts a write this cycle.
- upd_we  out  1  write valid.
- upd_clear  out  1  write is an init clear (counter to weakly-not-taken, BTB valid=0).
- upd_idx  out  BHT_IDX_W  table index.
- upd_pc  out  XLEN  training PC (0 during clear).
- upd_tg_pc  out  XLEN  training target (0 during clear).
- upd_taken  out  1  training direction.
- upd_cond  out  1  training record is conditional.
- init_busy  out  1  tables invalid; fetch must predict PC+4.
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy.
- ovf_err  out  1  sticky: a record was dropped.

Behaviour:
- State machine states: INIT, RUN.
- Reset (reset=0, asynchronous):
  - state=INIT, sweep counter=0, FIFO empty, ovf_err=0.
  - All outputs 0 while reset is low, except init_busy=1 and ex_stall=1.
- INIT:
  - upd_we=1, upd_clear=1, upd_idx=sweep counter.
  - Counter increments only on cycles with upd_ready=1.
  - When the write of index 2^BHT_IDX_W-1 is accepted, go to RUN at the next edge.
  - INIT therefore lasts at least 2^BHT_IDX_W cycles; init_busy=1 throughout.
  - EX enqueues are accepted during INIT and held. Nothing drains.
- RUN:
  - init_busy=0, upd_clear=0.
  - upd_we = FIFO non-empty. Payload is the head entry, combinational from registers.
  - upd_idx = head pc[BHT_IDX_W+1:2].
  - Pop when upd_we && upd_ready. FIFO issue order equals EX slot order, oldest first.
- Enqueue:
  - Slot 0 then slot 1, into consecutive tail positions. Slot 1 alone takes the next single position.
  - free = QDEPTH - q_count, computed from the registered count. A same-cycle pop does not free space for that cycle's enqueue.
  - ex_stall = (free < 2) || reset==0.
  - If ex_valid is presented while the valid records exceed free: enqueue as many as fit, in slot order, drop the rest, and set ovf_err (cleared only by reset).
- Pointers: head and tail wrap modulo QDEPTH. q_count is updated with simultaneous push(0..2) and pop(0..1), so the net change ranges from -1 to +2.
- Reset asserted mid-INIT or mid-RUN:
  - FIFO contents are discarded and the sweep restarts at index 0.
  - No partial write is considered committed.
- Stall from the port: upd_ready=0 holds all upd_* outputs stable.

Optional Feature:
- Macro: BP_UPD_COALESCE_EN.
- Defined:
  - Applies when ex_valid=2'b11 and both slots map to the same upd_idx.
  - Only slot 1 (younger) is enqueued; it occupies one entry.
  - ex_stall is unchanged.
  - The free check for that cycle needs only 1 entry.
- Undefined: both records are always enqueued as separate entries.

Test Plan:
- Reset sweep:
  - Stimulus: release reset with upd_ready=1.
  - Required: upd_we=upd_clear=1 with upd_idx 0..31 on 32 consecutive cycles, then init_busy=0. Nothing else is written.
- Sweep backpressure:
  - Stimulus: upd_ready=0 for 3 cycles at idx 7.
  - Required: upd_idx holds 7 for those cycles. INIT ends 3 cycles later, with no index skipped or repeated.
- Ordering:
  - Stimulus in RUN: ex_valid=11, pc0=0x8 taken tg 0x14, pc1=0xC not-taken.
  - Required: next cycle upd_pc=0x8, upd_idx=2, upd_taken=1. The following cycle upd_pc=0xC, upd_idx=3, upd_taken=0. Then upd_we=0.
- Fill and stall:
  - Stimulus: upd_ready=0; present ex_valid=11 twice.
  - Required: q_count=4, ex_stall=1.
  - Then present ex_valid=01 anyway: the record is dropped, ovf_err=1, q_count stays 4.
  - Then upd_ready=1: 4 pops in order, with ex_stall deasserting once q_count<=2.
- Simultaneous push/pop with wrap:
  - Stimulus: q_count=2 with head at slot 3 and upd_ready=1; push 0 records this cycle, then 2 records next cycle while popping.
  - Required: q_count goes 2 -> 1 -> 2, and the FIFO drains in order.
- Reset mid-RUN and coalescing:
  - Reset mid-RUN with 3 entries queued: FIFO empties and the sweep restarts at idx 0.
  - With BP_UPD_COALESCE_EN: pc0=0x80, pc1=0x100 (both idx 0) give exactly one write, carrying pc 0x100.
